// File: rtl/stack_pkg.sv
// Shared operand-stack definitions: op encoding and the op field type,
// reused by the control unit's decoder.
package stack_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NOP     = 3'd0;
    localparam op_t OP_PUSH    = 3'd1;
    localparam op_t OP_POP     = 3'd2;
    localparam op_t OP_DUP     = 3'd3;
    localparam op_t OP_SWAP    = 3'd4;
    localparam op_t OP_REPLACE = 3'd5;

endpackage

// File: rtl/stack_regfile.sv
// DEPTH x DATA_W stack storage with two write ports (so SWAP is one edge)
// and two combinational read ports for tos/nos.
module stack_regfile #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic [AW-1:0]     ra0,
    output logic [DATA_W-1:0] rd0,
    input  logic [AW-1:0]     ra1,
    output logic [DATA_W-1:0] rd1
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage update; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (we0) begin
            mem_r[wa0] <= wd0;
        end
        if (we1) begin
            mem_r[wa1] <= wd1;
        end
    end

    assign rd0 = mem_r[ra0];
    assign rd1 = mem_r[ra1];

endmodule

// File: rtl/param_stack.sv
// Parametrised operand stack: PUSH/POP/DUP/SWAP/REPLACE in one clock,
// occupancy count and sticky overflow/underflow flags.
module param_stack
    import stack_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  op_t               op,
    input  logic [DATA_W-1:0] din,
    input  logic              clr_err,
    output logic [DATA_W-1:0] tos,
    output logic [DATA_W-1:0] nos,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [CNT_W-1:0]  count_r, count_nxt_s;
    logic              ovf_r, ovf_nxt_s;
    logic              unf_r, unf_nxt_s;
    logic              we0_s, we1_s;
    logic [AW-1:0]     wa0_s, wa1_s;
    logic [DATA_W-1:0] wd0_s, wd1_s;
    logic [AW-1:0]     top_idx_s, nos_idx_s, push_idx_s;
    logic [DATA_W-1:0] rd_top_s, rd_nos_s;
    logic              empty_s, full_s, two_s;

    assign top_idx_s  = AW'(count_r - CNT_W'(1));
    assign nos_idx_s  = AW'(count_r - CNT_W'(2));
    assign push_idx_s = AW'(count_r);
    assign empty_s    = (count_r == CNT_W'(0));
    assign full_s     = (count_r == CNT_W'(DEPTH));
    assign two_s      = (count_r >= CNT_W'(2));

    stack_regfile #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_regfile (
        .clk (clk),
        .we0 (we0_s),
        .wa0 (wa0_s),
        .wd0 (wd0_s),
        .we1 (we1_s),
        .wa1 (wa1_s),
        .wd1 (wd1_s),
        .ra0 (top_idx_s),
        .rd0 (rd_top_s),
        .ra1 (nos_idx_s),
        .rd1 (rd_nos_s)
    );

    // Op decode: next count, flag updates and storage write requests.
    always_comb begin
        count_nxt_s = count_r;
        ovf_nxt_s   = clr_err ? 1'b0 : ovf_r;
        unf_nxt_s   = clr_err ? 1'b0 : unf_r;
        we0_s       = 1'b0;
        wa0_s       = push_idx_s;
        wd0_s       = din;
        we1_s       = 1'b0;
        wa1_s       = nos_idx_s;
        wd1_s       = tos;
        if (!reset) begin
            count_nxt_s = CNT_W'(0);
            ovf_nxt_s   = 1'b0;
            unf_nxt_s   = 1'b0;
        end else begin
            case (op)
                OP_PUSH: begin
                    if (full_s) begin
                        ovf_nxt_s = 1'b1;
                    end else begin
                        we0_s       = 1'b1;
                        count_nxt_s = count_r + CNT_W'(1);
                    end
                end
                OP_POP: begin
                    if (empty_s) begin
                        unf_nxt_s = 1'b1;
                    end else begin
                        count_nxt_s = count_r - CNT_W'(1);
                    end
                end
                OP_DUP: begin
                    if (empty_s) begin
                        unf_nxt_s = 1'b1;
                    end else if (full_s) begin
                        ovf_nxt_s = 1'b1;
                    end else begin
                        we0_s       = 1'b1;
                        wd0_s       = tos;
                        count_nxt_s = count_r + CNT_W'(1);
                    end
                end
                OP_SWAP: begin
                    if (!two_s) begin
                        unf_nxt_s = 1'b1;
                    end else begin
                        we0_s = 1'b1;
                        wa0_s = top_idx_s;
                        wd0_s = nos;
                        we1_s = 1'b1;
                    end
                end
                OP_REPLACE: begin
                    if (empty_s) begin
                        unf_nxt_s = 1'b1;
                    end else begin
                        we0_s = 1'b1;
                        wa0_s = top_idx_s;
                    end
                end
                default: begin
                    count_nxt_s = count_r;
                end
            endcase
        end
    end

    // Occupancy and sticky flag registers.
    always_ff @(posedge clk) begin
        count_r <= count_nxt_s;
        ovf_r   <= ovf_nxt_s;
        unf_r   <= unf_nxt_s;
    end

    // Read-side decode: entries above count read as zero.
    always_comb begin
        if (empty_s) begin
            tos = {DATA_W{1'b0}};
        end else begin
            tos = rd_top_s;
        end
        if (two_s) begin
            nos = rd_nos_s;
        end else begin
            nos = {DATA_W{1'b0}};
        end
    end

    assign count     = count_r;
    assign empty     = empty_s;
    assign full      = full_s;
    assign overflow  = ovf_r;
    assign underflow = unf_r;

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_param_stack;
    import stack_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef struct {
        string      tag;
        logic [7:0] tos;
        logic [7:0] nos;
        int         cnt;
        bit         ovf;
        bit         unf;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    op_t               op;
    logic [DATA_W-1:0] din;
    logic              clr_err;
    logic [DATA_W-1:0] tos, nos;
    logic [CNT_W-1:0]  count;
    logic              empty, full, overflow, underflow;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    param_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .din       (din),
        .clr_err   (clr_err),
        .tos       (tos),
        .nos       (nos),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string field, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d, expected %0d", tag, field, act, req);
        end
    endtask

    // Monitor: state after each consuming edge is compared at the next negedge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk(e.tag, "tos",       int'(tos),       int'(e.tos));
                chk(e.tag, "nos",       int'(nos),       int'(e.nos));
                chk(e.tag, "count",     int'(count),     e.cnt);
                chk(e.tag, "empty",     int'(empty),     (e.cnt == 0) ? 1 : 0);
                chk(e.tag, "full",      int'(full),      (e.cnt == DEPTH) ? 1 : 0);
                chk(e.tag, "overflow",  int'(overflow),  int'(e.ovf));
                chk(e.tag, "underflow", int'(underflow), int'(e.unf));
            end
        end
    end

    task automatic step(input string tag, input logic rst_n, input op_t o,
                        input logic [7:0] d, input logic clr,
                        input logic [7:0] e_tos, input logic [7:0] e_nos,
                        input int e_cnt, input bit e_ovf, input bit e_unf);
        exp_t e;
        reset   = rst_n;
        op      = o;
        din     = d;
        clr_err = clr;
        @(posedge clk);
        e.tag = tag; e.tos = e_tos; e.nos = e_nos; e.cnt = e_cnt; e.ovf = e_ovf; e.unf = e_unf;
        exp_q.push_back(e);
        #1;
        reset   = 1'b1;
        op      = OP_NOP;
        clr_err = 1'b0;
    endtask

    initial begin
        reset = 1'b0; op = OP_NOP; din = 8'd0; clr_err = 1'b0;
        step("reset",      1'b0, OP_NOP,     8'd0,  1'b0, 8'd0,  8'd0, 0, 1'b0, 1'b0);
        step("push5",      1'b1, OP_PUSH,    8'd5,  1'b0, 8'd5,  8'd0, 1, 1'b0, 1'b0);
        step("push7",      1'b1, OP_PUSH,    8'd7,  1'b0, 8'd7,  8'd5, 2, 1'b0, 1'b0);
        step("replace12",  1'b1, OP_REPLACE, 8'd12, 1'b0, 8'd12, 8'd5, 2, 1'b0, 1'b0);
        step("pop_a",      1'b1, OP_POP,     8'd0,  1'b0, 8'd5,  8'd0, 1, 1'b0, 1'b0);
        step("pop_b",      1'b1, OP_POP,     8'd0,  1'b0, 8'd0,  8'd0, 0, 1'b0, 1'b0);
        step("pop_empty",  1'b1, OP_POP,     8'd0,  1'b0, 8'd0,  8'd0, 0, 1'b0, 1'b1);
        step("clr_vs_unf", 1'b1, OP_POP,     8'd0,  1'b1, 8'd0,  8'd0, 0, 1'b0, 1'b1);
        step("clr_alone",  1'b1, OP_NOP,     8'd0,  1'b1, 8'd0,  8'd0, 0, 1'b0, 1'b0);
        step("replace_mt", 1'b1, OP_REPLACE, 8'd4,  1'b0, 8'd0,  8'd0, 0, 1'b0, 1'b1);
        step("dup_empty",  1'b1, OP_DUP,     8'd0,  1'b1, 8'd0,  8'd0, 0, 1'b0, 1'b1);
        step("clr2",       1'b1, OP_NOP,     8'd0,  1'b1, 8'd0,  8'd0, 0, 1'b0, 1'b0);
        for (int i = 1; i <= DEPTH; i++) begin
            step($sformatf("fill%0d", i), 1'b1, OP_PUSH, 8'(i), 1'b0,
                 8'(i), 8'(i - 1), i, 1'b0, 1'b0);
        end
        step("push_full",  1'b1, OP_PUSH,    8'd99, 1'b0, 8'd16, 8'd15, 16, 1'b1, 1'b0);
        step("dup_full",   1'b1, OP_DUP,     8'd0,  1'b0, 8'd16, 8'd15, 16, 1'b1, 1'b0);
        step("op7_clr",    1'b1, op_t'(3'd7), 8'd0, 1'b1, 8'd16, 8'd15, 16, 1'b0, 1'b0);
        step("op6_nop",    1'b1, op_t'(3'd6), 8'd1, 1'b0, 8'd16, 8'd15, 16, 1'b0, 1'b0);
        step("reset2",     1'b0, OP_NOP,     8'd0,  1'b0, 8'd0,  8'd0, 0, 1'b0, 1'b0);
        step("push3",      1'b1, OP_PUSH,    8'd3,  1'b0, 8'd3,  8'd0, 1, 1'b0, 1'b0);
        step("push9",      1'b1, OP_PUSH,    8'd9,  1'b0, 8'd9,  8'd3, 2, 1'b0, 1'b0);
        step("swap",       1'b1, OP_SWAP,    8'd0,  1'b0, 8'd3,  8'd9, 2, 1'b0, 1'b0);
        step("dup",        1'b1, OP_DUP,     8'd0,  1'b0, 8'd3,  8'd3, 3, 1'b0, 1'b0);
        step("pop_c",      1'b1, OP_POP,     8'd0,  1'b0, 8'd3,  8'd9, 2, 1'b0, 1'b0);
        step("pop_d",      1'b1, OP_POP,     8'd0,  1'b0, 8'd9,  8'd0, 1, 1'b0, 1'b0);
        step("swap_one",   1'b1, OP_SWAP,    8'd0,  1'b0, 8'd9,  8'd0, 1, 1'b0, 1'b1);
        step("reset3",     1'b0, OP_NOP,     8'd0,  1'b0, 8'd0,  8'd0, 0, 1'b0, 1'b0);
        step("push5b",     1'b1, OP_PUSH,    8'd5,  1'b0, 8'd5,  8'd0, 1, 1'b0, 1'b0);
        step("push7b",     1'b1, OP_PUSH,    8'd7,  1'b0, 8'd7,  8'd5, 2, 1'b0, 1'b0);
        step("rst_push",   1'b0, OP_PUSH,    8'd8,  1'b0, 8'd0,  8'd0, 0, 1'b0, 1'b0);
        step("push8",      1'b1, OP_PUSH,    8'd8,  1'b0, 8'd8,  8'd0, 1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
